fetch_redirect_ctrl: RTL and testbench
======================================

# fetch_redirect_ctrl

Control block that drives the fetch stage's PC-steering inputs: `PCWrite`, `or_out`, `Branchreg`, `add_pc` and `read_data_1`. It resolves branches in EX, detects load-use hazards between ID/EX and IF/ID, and sequences the squash window that follows a redirect. It sits between the EX-stage branch logic, the ID/EX and IF/ID pipeline registers, and the fetch stage.

## Interface
- `FLUSH_CYCLES`, default 2: cycles after a redirect during which EX branch inputs are masked (1..7).
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `ex_valid`  in  1  EX stage holds a real instruction.
- `ex_cbranch`  in  1  EX instruction is CBZ/CBNZ/B.cond.
- `ex_cond_true`  in  1  condition evaluated true for `ex_cbranch`.
- `ex_ubranch`  in  1  EX instruction is B/BL.
- `ex_breg`  in  1  EX instruction is BR.
- `ex_target`  in  64  PC-relative target computed in EX.
- `ex_reg_target`  in  64  register value for BR.
- `id_ex_mem_read`  in  1  ID/EX instruction is a load.
- `id_ex_rd`  in  5  ID/EX destination register.
- `if_id_valid`  in  1  IF/ID holds a real instruction.
- `if_id_rn`, `if_id_rm`  in  5 each  IF/ID source registers.
- `PCWrite`  out  1  1 = PC advances, 0 = PC holds.
- `or_out`  out  1  select `add_pc` over PC+4.
- `Branchreg`  out  1  select `read_data_1` (BR).
- `add_pc`  out  64  branch target to fetch.
- `read_data_1`  out  64  register target to fetch.
- `if_id_write`  out  1  IF/ID load enable.
- `if_id_flush`  out  1  clear IF/ID to bubble at next edge.
- `id_ex_bubble`  out  1  insert bubble into ID/EX at next edge.
- `state`  out  2  current FSM state (debug).

## Operation
- Taken = `ex_valid` & (`ex_ubranch` | `ex_breg` | (`ex_cbranch` & `ex_cond_true`)). Branch inputs are qualified only in RUN and STALL.
- Redirect (taken): `or_out` = 1, `Branchreg` = `ex_breg`, `PCWrite` = 1, `if_id_flush` = 1, `id_ex_bubble` = 1. The FSM moves to FLUSH and the counter loads `FLUSH_CYCLES`-1.
- `add_pc` = `ex_target`. `read_data_1` = `ex_reg_target`. Both are combinational passthroughs, valid only while `or_out` or `Branchreg` is asserted.
- Load-use hazard: `id_ex_mem_read` & `id_ex_rd` != 31 & `if_id_valid` & (`id_ex_rd` == `if_id_rn` | `id_ex_rd` == `if_id_rm`).
  - Outputs: `PCWrite` = 0, `if_id_write` = 0, `id_ex_bubble` = 1.
  - The FSM moves to STALL for exactly one cycle.
- Priority: a redirect beats a load-use stall in the same cycle. The stalled instruction is wrong-path and is flushed.
- FSM states:
  - RUN (0): normal operation. Redirect → FLUSH; hazard → STALL; otherwise RUN.
  - STALL (1): hazard detection is suppressed and `PCWrite` = 1. Redirect → FLUSH; otherwise RUN.
  - FLUSH (2): EX branch inputs are ignored; `if_id_flush` = 0 and `PCWrite` = 1. Load-use detection stays active, but a stall moves the FSM to STALL only once the counter reaches 0. The counter decrements each cycle; at 0 the FSM moves to RUN.
  - State 3 is unreachable and recovers to RUN.
- Default outputs: `PCWrite` = 1, `if_id_write` = 1, all others 0.

## Timing
- All steering outputs are combinational from the inputs and registered state. Fetch sees a redirect in the same cycle and loads the target at the next edge.
- Branch penalty equals 2 squashed slots (IF/ID and ID/EX).
- Load-use penalty is 1 cycle.
- Reset (async, `reset` = 0): FSM = RUN, counter = 0, all outputs at defaults (`PCWrite` = 1, `if_id_write` = 1, others 0). Reset asserted mid-FLUSH abandons the window immediately.
- When `FLUSH_CYCLES` = 1, FLUSH lasts one cycle.

## Configuration
- `FETCH_REDIRECT_STATS_EN` defined:
  - Adds output `redirect_count` [31:0], incremented once per redirect.
  - Adds output `stall_count` [31:0], incremented once per load-use stall cycle.
  - Both counters saturate at 0xFFFFFFFF and clear on reset.
- Undefined: the ports and counters are absent. Functional behaviour is identical.

## Test plan
- Reset, then idle → `PCWrite` = 1, `or_out` = 0, `state` = 0, every cycle.
- `ex_valid` = 1, `ex_cbranch` = 1, `ex_cond_true` = 1, `ex_target` = 0x40 → same cycle `or_out` = 1, `add_pc` = 0x40, `if_id_flush` = 1. Then `state` = 2 for 2 cycles, then 0.
- Load X1 in ID/EX, `if_id_rn` = 1 → `PCWrite` = 0, `id_ex_bubble` = 1 for exactly 1 cycle. With `id_ex_rd` = 31, no stall.
- Redirect and hazard in the same cycle → redirect wins: `PCWrite` = 1, `if_id_flush` = 1, `state` → 2.
- BR with `ex_reg_target` = 0x1000 → `Branchreg` = 1, `read_data_1` = 0x1000. A taken branch asserted during FLUSH is ignored. `reset` pulse mid-FLUSH → `state` = 0 asynchronously.
- With `FETCH_REDIRECT_STATS_EN`: 3 redirects and 2 stalls → `redirect_count` = 3, `stall_count` = 2. Preloaded counter at 0xFFFFFFFF stays saturated.

Source files
------------

// File: rtl/fetch_redirect_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_redirect_ctrl_if
//
// Groups every signal between the fetch redirect controller and its
// neighbours: the EX-stage branch resolution inputs, the ID/EX and IF/ID
// hazard inputs, and the PC-steering / pipeline-register control outputs.
//
// Modports:
//   master - the pipeline side: drives EX / ID/EX / IF/ID inputs and
//            consumes the steering outputs.
//   slave  - the controller: consumes the inputs, drives the outputs.
//
// Signal summary:
//   ex_valid, ex_cbranch, ex_cond_true, ex_ubranch, ex_breg   EX branch info
//   ex_target[63:0], ex_reg_target[63:0]                      EX targets
//   id_ex_mem_read, id_ex_rd[4:0]                             ID/EX load info
//   if_id_valid, if_id_rn[4:0], if_id_rm[4:0]                 IF/ID sources
//   PCWrite, or_out, Branchreg, add_pc, read_data_1           fetch steering
//   if_id_write, if_id_flush, id_ex_bubble                    pipe reg control
//   state[1:0]                                                FSM debug view
//   redirect_count, stall_count                               only when
//                                         FETCH_REDIRECT_STATS_EN is defined
// ---------------------------------------------------------------------------
interface fetch_redirect_ctrl_if;
    logic        ex_valid;
    logic        ex_cbranch;
    logic        ex_cond_true;
    logic        ex_ubranch;
    logic        ex_breg;
    logic [63:0] ex_target;
    logic [63:0] ex_reg_target;
    logic        id_ex_mem_read;
    logic [4:0]  id_ex_rd;
    logic        if_id_valid;
    logic [4:0]  if_id_rn;
    logic [4:0]  if_id_rm;

    logic        PCWrite;
    logic        or_out;
    logic        Branchreg;
    logic [63:0] add_pc;
    logic [63:0] read_data_1;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic [1:0]  state;
`ifdef FETCH_REDIRECT_STATS_EN
    logic [31:0] redirect_count;
    logic [31:0] stall_count;
`endif

    modport master (
        output ex_valid, ex_cbranch, ex_cond_true, ex_ubranch, ex_breg,
               ex_target, ex_reg_target, id_ex_mem_read, id_ex_rd,
               if_id_valid, if_id_rn, if_id_rm,
        input  PCWrite, or_out, Branchreg, add_pc, read_data_1,
               if_id_write, if_id_flush, id_ex_bubble, state
`ifdef FETCH_REDIRECT_STATS_EN
        , input redirect_count, stall_count
`endif
    );

    modport slave (
        input  ex_valid, ex_cbranch, ex_cond_true, ex_ubranch, ex_breg,
               ex_target, ex_reg_target, id_ex_mem_read, id_ex_rd,
               if_id_valid, if_id_rn, if_id_rm,
        output PCWrite, or_out, Branchreg, add_pc, read_data_1,
               if_id_write, if_id_flush, id_ex_bubble, state
`ifdef FETCH_REDIRECT_STATS_EN
        , output redirect_count, stall_count
`endif
    );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_redirect_ctrl
//
// Steers the fetch stage. Resolves taken branches in EX and redirects fetch
// in the same cycle, detects load-use hazards between ID/EX and IF/ID and
// holds the PC for one cycle, and masks EX branch inputs for FLUSH_CYCLES
// cycles after a redirect while the squashed wrong-path slots drain.
//
// Parameters:
//   FLUSH_CYCLES  cycles after a redirect during which EX branches are
//                 ignored (1..7, default 2).
//
// Ports:
//   clock   rising-edge clock
//   reset   asynchronous, active-low reset
//   bus     fetch_redirect_ctrl_if.slave (all pipeline inputs/outputs)
//
// Optional feature:
//   FETCH_REDIRECT_STATS_EN  adds saturating 32-bit redirect_count and
//                            stall_count outputs on the interface.
// ---------------------------------------------------------------------------
module fetch_redirect_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    fetch_redirect_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_STALL   = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_e;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic taken;
    logic hazard;
    logic redirect;
    logic stall;

    logic pc_write;
    logic or_sel;
    logic breg_sel;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;

    assign taken = bus.ex_valid &
                   (bus.ex_ubranch | bus.ex_breg | (bus.ex_cbranch & bus.ex_cond_true));

    // X31 is XZR: a load into it never creates a real dependency.
    assign hazard = bus.id_ex_mem_read & (bus.id_ex_rd != 5'd31) & bus.if_id_valid &
                    ((bus.id_ex_rd == bus.if_id_rn) | (bus.id_ex_rd == bus.if_id_rm));

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        redirect    = 1'b0;
        stall       = 1'b0;
        pc_write    = 1'b1;
        or_sel      = 1'b0;
        breg_sel    = 1'b0;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (taken) begin
                    redirect = 1'b1;
                end else if (hazard) begin
                    stall = 1'b1;
                end
            end
            ST_STALL: begin
                // The dependent instruction has already been held once, so
                // hazard detection is suppressed here.
                state_d = ST_RUN;
                if (taken) begin
                    redirect = 1'b1;
                end
            end
            ST_FLUSH: begin
                // Branch inputs belong to squashed instructions and are
                // ignored. A load-use stall is honoured only on the last
                // cycle of the window.
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                    stall   = hazard;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase

        // A redirect outranks a stall: the stalled instruction is wrong-path.
        if (redirect) begin
            or_sel      = 1'b1;
            breg_sel    = bus.ex_breg;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_d     = ST_FLUSH;
            cnt_d       = FLUSH_LOAD;
        end else if (stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            state_d     = ST_STALL;
        end
    end

    assign bus.PCWrite      = pc_write;
    assign bus.or_out       = or_sel;
    assign bus.Branchreg    = breg_sel;
    assign bus.add_pc       = bus.ex_target;
    assign bus.read_data_1  = bus.ex_reg_target;
    assign bus.if_id_write  = ifid_write;
    assign bus.if_id_flush  = ifid_flush;
    assign bus.id_ex_bubble = idex_bubble;
    assign bus.state        = state_q;

`ifdef FETCH_REDIRECT_STATS_EN
    logic [31:0] redirect_cnt_q;
    logic [31:0] stall_cnt_q;

    // Both counters stick at all-ones instead of wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            redirect_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            if (redirect && (redirect_cnt_q != '1)) begin
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
            end
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign bus.redirect_count = redirect_cnt_q;
    assign bus.stall_count    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_redirect_ctrl
//
// Directed scenarios followed by randomized traffic. The reference model
// tracks the pipeline as "cycles left in the masked window" and "was the
// previous cycle a stall", and derives every expected output from the
// branch / load-use rules directly.
// ---------------------------------------------------------------------------
module tb_fetch_redirect_ctrl;

    localparam int unsigned FC = 2;

    logic clock;
    logic reset;

    fetch_redirect_ctrl_if bus ();

    fetch_redirect_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int win_left    = 0;   // masked cycles remaining, current one included
    bit after_stall = 0;
    int m_redirects = 0;
    int m_stalls    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input bit cb, input bit ct, input bit ub, input bit br,
                         input logic [63:0] tgt, input logic [63:0] rtgt,
                         input bit mr, input logic [4:0] rd,
                         input bit ifv, input logic [4:0] rn, input logic [4:0] rm);
        bus.ex_valid       = v;
        bus.ex_cbranch     = cb;
        bus.ex_cond_true   = ct;
        bus.ex_ubranch     = ub;
        bus.ex_breg        = br;
        bus.ex_target      = tgt;
        bus.ex_reg_target  = rtgt;
        bus.id_ex_mem_read = mr;
        bus.id_ex_rd       = rd;
        bus.if_id_valid    = ifv;
        bus.if_id_rn       = rn;
        bus.if_id_rm       = rm;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 64'h0, 64'h0, 0, 5'd0, 0, 5'd0, 5'd0);
    endtask

    // Called at a falling edge after inputs are driven; checks the current
    // cycle, advances the model across the rising edge, returns at the next
    // falling edge.
    task automatic step();
        bit taken, haz, masked, redirect, stall;
        logic [1:0] exp_state;
        #1;
        taken  = bus.ex_valid && (bus.ex_ubranch || bus.ex_breg ||
                                  (bus.ex_cbranch && bus.ex_cond_true));
        haz    = bus.id_ex_mem_read && bus.id_ex_rd != 5'd31 && bus.if_id_valid &&
                 (bus.id_ex_rd == bus.if_id_rn || bus.id_ex_rd == bus.if_id_rm);
        masked = win_left > 0;
        redirect = taken && !masked;
        stall    = haz && !redirect && !after_stall && win_left <= 1;
        exp_state = masked ? 2'd2 : (after_stall ? 2'd1 : 2'd0);

        check("state",        bus.state,        exp_state);
        check("PCWrite",      bus.PCWrite,      !stall);
        check("if_id_write",  bus.if_id_write,  !stall);
        check("or_out",       bus.or_out,       redirect);
        check("Branchreg",    bus.Branchreg,    redirect && bus.ex_breg);
        check("if_id_flush",  bus.if_id_flush,  redirect);
        check("id_ex_bubble", bus.id_ex_bubble, redirect || stall);
        if (redirect) check("add_pc", bus.add_pc, bus.ex_target);
        if (redirect && bus.ex_breg) check("read_data_1", bus.read_data_1, bus.ex_reg_target);

        @(posedge clock);
        if (redirect) begin
            win_left    = FC;
            after_stall = 0;
            m_redirects++;
        end else if (stall) begin
            win_left    = 0;
            after_stall = 1;
            m_stalls++;
        end else begin
            win_left    = (win_left > 0) ? win_left - 1 : 0;
            after_stall = 0;
        end
        @(negedge clock);
    endtask

    task automatic model_reset();
        win_left    = 0;
        after_stall = 0;
        m_redirects = 0;
        m_stalls    = 0;
    endtask

    initial begin
        logic [4:0] regs [5];
        regs[0] = 5'd0; regs[1] = 5'd1; regs[2] = 5'd2; regs[3] = 5'd3; regs[4] = 5'd31;

        idle();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_PCWrite",     bus.PCWrite,     1'b1);
        check("rst_if_id_write", bus.if_id_write, 1'b1);
        check("rst_or_out",      bus.or_out,      1'b0);
        check("rst_state",       bus.state,       2'd0);
        reset = 1'b1;
        model_reset();

        // Idle
        repeat (3) step();

        // Taken conditional branch to 0x40, then the masked window drains
        drive(1, 1, 1, 0, 0, 64'h40, 64'h0, 0, 5'd0, 0, 5'd0, 5'd0);
        step();
        idle();
        repeat (3) step();

        // Load X1 feeding rn: one stall cycle, then held inputs do not stall again
        drive(0, 0, 0, 0, 0, 64'h0, 64'h0, 1, 5'd1, 1, 5'd1, 5'd7);
        repeat (2) step();
        // Load into XZR never stalls
        drive(0, 0, 0, 0, 0, 64'h0, 64'h0, 1, 5'd31, 1, 5'd31, 5'd31);
        step();

        // Redirect and hazard together: redirect wins
        drive(1, 0, 0, 1, 0, 64'h80, 64'h0, 1, 5'd2, 1, 5'd9, 5'd2);
        step();
        idle();
        repeat (3) step();

        // BR to 0x1000, then a taken branch inside the window is ignored
        drive(1, 0, 0, 0, 1, 64'h0, 64'h1000, 0, 5'd0, 0, 5'd0, 5'd0);
        step();
        drive(1, 0, 0, 1, 0, 64'h200, 64'h0, 0, 5'd0, 0, 5'd0, 5'd0);
        step();
        idle();
        repeat (2) step();

        // Reset pulse mid-window returns to RUN without a clock edge
        drive(1, 0, 0, 1, 0, 64'h300, 64'h0, 0, 5'd0, 0, 5'd0, 5'd0);
        step();
        idle();
        reset = 1'b0;
        #1;
        check("async_rst_state",   bus.state,   2'd0);
        check("async_rst_PCWrite", bus.PCWrite, 1'b1);
        reset = 1'b1;
        model_reset();
        @(negedge clock);
        step();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit v, cb, ct, ub, br, mr, ifv;
            v   = ($urandom_range(0, 3) == 0);
            cb  = $urandom_range(0, 1);
            ct  = $urandom_range(0, 1);
            ub  = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 3) == 0);
            mr  = $urandom_range(0, 1);
            ifv = ($urandom_range(0, 3) != 0);
            drive(v, cb, ct, ub, br, {$urandom, $urandom}, {$urandom, $urandom},
                  mr, regs[$urandom_range(0, 4)],
                  ifv, regs[$urandom_range(0, 4)], regs[$urandom_range(0, 4)]);
            step();
        end

`ifdef FETCH_REDIRECT_STATS_EN
        check("redirect_count", bus.redirect_count, 64'(m_redirects));
        check("stall_count",    bus.stall_count,    64'(m_stalls));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation did not finish");
    end

endmodule
